// File: rtl/disp_pkg.sv
// Shared constants and types for 7-segment display blocks.
// Active-low segment patterns {g,f,e,d,c,b,a}, anode-off value, digit index type.
package disp_pkg;

  typedef logic [1:0] dig_idx_t;

  localparam logic [3:0] AN_OFF   = 4'b1111;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_A    = SEG_DASH;
  localparam logic [6:0] SEG_B    = SEG_DASH;
  localparam logic [6:0] SEG_C    = SEG_DASH;
  localparam logic [6:0] SEG_D    = SEG_DASH;
  localparam logic [6:0] SEG_E    = SEG_DASH;
  localparam logic [6:0] SEG_F    = SEG_DASH;

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD to active-low 7-segment decoder; 10..15 show a dash.
// Ports: i_dig[3:0] digit value, o_seg[6:0] segments {g,f,e,d,c,b,a}.
module seg7_dec
  import disp_pkg::*;
(
  input  logic [3:0] i_dig,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    unique case (i_dig)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/disp_scan7.sv
// 4-digit common-anode 7-seg scanner with per-frame digit snapshot.
// Ports: clk, rst (sync, active-high), hour1/hour0/min1/min0 BCD in,
// an[3:0] anodes, seg[6:0], dp (all active low). Option: DISP_COLON_BLINK_EN.
module disp_scan7
  import disp_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] hour1,
  input  logic [3:0] hour0,
  input  logic [2:0] min1,
  input  logic [3:0] min0,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] r_cnt;
  dig_idx_t      r_idx;
  logic [12:0]   r_snap;
  logic          w_wrap;
  logic [3:0]    w_dig;
  logic [6:0]    w_seg;
  logic          w_dp_sep;

  assign w_wrap = (r_cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_snap <= '0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap)
        r_idx <= r_idx + 1'b1;
      // Latch new digits only at the frame boundary to avoid tearing.
      if (w_wrap && r_idx == 2'd3)
        r_snap <= {hour1, hour0, min1, min0};
    end
  end

  always_comb begin
    w_dig = '0;
    unique case (r_idx)
      2'd0: w_dig = r_snap[3:0];
      2'd1: w_dig = {1'b0, r_snap[6:4]};
      2'd2: w_dig = r_snap[10:7];
      2'd3: w_dig = {2'b00, r_snap[12:11]};
    endcase
  end

  seg7_dec u_dec (
    .i_dig (w_dig),
    .o_seg (w_seg)
  );

`ifdef DISP_COLON_BLINK_EN
  localparam int HALF = CLK_HZ / 2;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [BW-1:0] r_bcnt;
  logic          r_blink;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcnt  <= '0;
      r_blink <= 1'b0;
    end else if (r_bcnt == BW'(HALF - 1)) begin
      r_bcnt  <= '0;
      r_blink <= ~r_blink;
    end else begin
      r_bcnt <= r_bcnt + 1'b1;
    end
  end

  assign w_dp_sep = ~r_blink;
`else
  assign w_dp_sep = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else if (r_cnt < CW'(BLANK_CYC)) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << r_idx);
      // Blank a leading zero on the hours tens digit, anode stays on.
      seg <= (r_idx == 2'd3 && r_snap[12:11] == 2'b00) ? SEG_OFF : w_seg;
      dp  <= (r_idx == 2'd2) ? w_dp_sep : 1'b1;
    end
  end

endmodule

// File: tb/tb_disp_scan7.sv
// Self-checking bench for disp_scan7 with a frame-level reference model.
// Small parameters: SCAN_DIV=4, BLANK_CYC=1, CLK_HZ=16.
module tb_disp_scan7;

  localparam int SD    = 4;
  localparam int BLANK = 1;
  localparam int HZ    = 16;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] hour1 = '0;
  logic [3:0] hour0 = '0;
  logic [2:0] min1 = '0;
  logic [3:0] min0 = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  int pos = 0;
  int s_h1 = 0, s_h0 = 0, s_m1 = 0, s_m0 = 0;

  logic [3:0] an_tbl [4];
  logic [6:0] seg_tbl [16];

  disp_scan7 #(
    .CLK_HZ    (HZ),
    .SCAN_DIV  (SD),
    .BLANK_CYC (BLANK)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .hour1 (hour1),
    .hour0 (hour0),
    .min1  (min1),
    .min0  (min0),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs,
                     input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s pos=%0d observed=%b expected=%b", tag, pos, obs, exp);
    end
  endtask

  // One clock: predict the outputs from the display-time position,
  // then compare 1 time unit after the edge.
  task automatic step();
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    int c, ix, dg, blink;
    @(posedge clk);
    ea = 4'hF; es = 7'h7F; ed = 1'b1;
    if (rst) begin
      pos = 0;
      s_h1 = 0; s_h0 = 0; s_m1 = 0; s_m0 = 0;
    end else begin
      c     = pos % SD;
      ix    = (pos / SD) % 4;
      blink = (pos / (HZ / 2)) % 2;
      if (c >= BLANK) begin
        ea = an_tbl[ix];
        case (ix)
          0: dg = s_m0;
          1: dg = s_m1;
          2: dg = s_h0;
          default: dg = s_h1;
        endcase
        es = (ix == 3 && s_h1 == 0) ? 7'h7F : seg_tbl[dg];
`ifdef DISP_COLON_BLINK_EN
        ed = (ix == 2) ? (blink == 0) : 1'b1;
`else
        ed = (ix == 2) ? 1'b0 : 1'b1;
`endif
      end
      if (pos % FRAME == FRAME - 1) begin
        s_h1 = int'(hour1); s_h0 = int'(hour0);
        s_m1 = int'(min1);  s_m0 = int'(min0);
      end
      pos++;
    end
    #1;
    chk("an",  {3'b000, an}, {3'b000, ea});
    chk("seg", seg, es);
    chk("dp",  {6'b0, dp}, {6'b0, ed});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic align_frame();
    int guard = 0;
    while (pos % FRAME != 0 && guard < 2 * FRAME) begin
      step();
      guard++;
    end
  endtask

  initial begin
    an_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

    // Power-on reset
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    steps(2);
    chk("slot0_an", {3'b000, an}, 7'b0001110);
    chk("slot0_seg", seg, 7'b1000000);

    // Random traffic, then reset mid-frame for 3 cycles
    hour1 = 2'($urandom); hour0 = 4'($urandom);
    min1 = 3'($urandom);  min0 = 4'($urandom);
    steps(FRAME + 6);
    rst = 1'b1;
    step();
    chk("rst_an", {3'b000, an}, 7'b0001111);
    chk("rst_seg", seg, 7'b1111111);
    steps(2);
    rst = 1'b0;
    steps(2);
    chk("rel_an", {3'b000, an}, 7'b0001110);

    // Static 12:34 across two frames
    hour1 = 2'd1; hour0 = 4'd2; min1 = 3'd3; min0 = 4'd4;
    align_frame();
    steps(2 * FRAME);

    // Tearing: min0 changes 4->7 during idx1
    steps(SD + 1);
    min0 = 4'd7;
    steps(2 * FRAME);

    // Leading zero and dash
    hour1 = 2'd0; hour0 = 4'd15;
    align_frame();
    steps(2 * FRAME);

    // Random digits changed at random points
    for (int k = 0; k < 40; k++) begin
      hour1 = 2'($urandom); hour0 = 4'($urandom);
      min1 = 3'($urandom);  min0 = 4'($urandom);
      steps($urandom_range(1, 2 * FRAME));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
